// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: the upstream valid/ready/data, the downstream valid/ready/data,
// plus the flush request and the occupancy count.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             flush;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register (main + skid) that cuts the ready path between pipeline stages.
// out_data always shows main, and in_ready is decoded from state only, so no input reaches it combinationally.
module pipe_skid_reg #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic           clock,
    input  logic           reset,
    pipe_skid_reg_if.slave bus,
    output logic [1:0]     o_dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Once valid is raised, the producer holds it and the data until that transfer occurs.
    // A flush cycle squashes that cycle's transfer on both sides.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [1:0]       w_count;

    assign w_in_ready  = (r_state != ST_TWO);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = bus.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_nxt  = bus.in_data;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = bus.in_data;
                end else if (w_in_fire) begin
                    w_skid_nxt  = bus.in_data;
                    w_state_nxt = ST_TWO;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_fire) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush empties the block but leaves the data registers untouched.
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_main  <= INIT;
            r_skid  <= INIT;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_count = 2'd0;
        case (r_state)
            ST_EMPTY: w_count = 2'd0;
            ST_ONE:   w_count = 2'd1;
            ST_TWO:   w_count = 2'd2;
            default:  w_count = 2'd0;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main;
    assign bus.count     = w_count;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg plus a short randomized run against a queue reference model.
module tb_pipe_skid_reg;
    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic [1:0]   dbg_state;
    int           n_checks;
    int           n_fail;
    logic [W-1:0] exp_q[$];

    pipe_skid_reg_if #(.WIDTH(W)) bus ();

    pipe_skid_reg #(
        .WIDTH(W),
        .INIT ('0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 32'h1234, 1'b1, 1'b1);
        tick();
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        n_checks++; if (bus.count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd1 || bus.out_data !== 32'hA) begin n_fail++; $display("FAIL stall_first got=%0d/%0h exp=1/a", bus.count, bus.out_data); end
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full got=%0d/%0b exp=2/0", bus.count, bus.in_ready); end
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd2 || bus.out_data !== 32'hA) begin n_fail++; $display("FAIL stall_hold got=%0d/%0h exp=2/a", bus.count, bus.out_data); end
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        tick();
        n_checks++; if (bus.out_data !== 32'hB || bus.count !== 2'd1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_drain_b got=%0h/%0d exp=b/1", bus.out_data, bus.count); end
        tick();
        n_checks++; if (bus.out_data !== 32'hC || bus.count !== 2'd1) begin n_fail++; $display("FAIL stall_drain_c got=%0h/%0d exp=c/1", bus.out_data, bus.count); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'hC) begin n_fail++; $display("FAIL stall_empty got=%0b/%0h exp=0/c", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i) || bus.count !== 2'd1) begin
                n_fail++;
                $display("FAIL stream_%0d got=%0b/%0h/%0d exp=1/%0h/1", i, bus.out_valid, bus.out_data, bus.count, i);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd0) begin n_fail++; $display("FAIL stream_end_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h6, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=2", bus.count); end
        drive(1'b1, 32'h7, 1'b1, 1'b1);
        tick();
        n_checks++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got=%0d/%0b/%0b exp=0/0/1", bus.count, bus.out_valid, bus.in_ready); end
        n_checks++; if (bus.out_data !== 32'h5) begin n_fail++; $display("FAIL flush_keep_main got=%0h exp=5", bus.out_data); end
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd1 || bus.out_data !== 32'h8) begin n_fail++; $display("FAIL flush_after_push got=%0d/%0h exp=1/8", bus.count, bus.out_data); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd0) begin n_fail++; $display("FAIL flush_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_reset_in_two();
        drive(1'b1, 32'h1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h2, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.count !== 2'd2) begin n_fail++; $display("FAIL rst2_pre_count got=%0d exp=2", bus.count); end
        reset = 1'b0;
        drive(1'b1, 32'h3, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rst2_empty got=%0d/%0b/%0h exp=0/0/0", bus.count, bus.out_valid, bus.out_data); end
        drive(1'b1, 32'h9, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h9 || bus.count !== 2'd1) begin n_fail++; $display("FAIL rst2_push got=%0b/%0h/%0d exp=1/9/1", bus.out_valid, bus.out_data, bus.count); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic         v;
        logic         rdy;
        logic         fl;
        logic [W-1:0] d;
        logic         r0;
        bit           in_f;
        bit           out_f;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            n_checks++;
            if (bus.count !== 2'(exp_q.size()) || bus.out_valid !== (exp_q.size() > 0) || bus.in_ready !== (exp_q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_state_c%0d got=%0d/%0b/%0b exp_size=%0d", c, bus.count, bus.out_valid, bus.in_ready, exp_q.size());
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                if (bus.out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data_c%0d got=%0h exp=%0h", c, bus.out_data, exp_q[0]);
                end
            end
            v   = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 15) == 0);
            d   = W'($urandom);
            r0  = bus.in_ready;
            drive(v, d, ~rdy, fl);
            #1;
            n_checks++; if (bus.in_ready !== r0) begin n_fail++; $display("FAIL rand_ready_comb_c%0d got=%0b exp=%0b", c, bus.in_ready, r0); end
            drive(v, d, rdy, fl);
            #1;
            n_checks++; if (bus.in_ready !== r0) begin n_fail++; $display("FAIL rand_ready_comb2_c%0d got=%0b exp=%0b", c, bus.in_ready, r0); end
            in_f  = v && (exp_q.size() < 2);
            out_f = rdy && (exp_q.size() > 0);
            if (fl) begin
                exp_q.delete();
            end else begin
                if (out_f) void'(exp_q.pop_front());
                if (in_f) exp_q.push_back(d);
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clock);
        test_reset();
        test_stall();
        test_stream();
        test_flush();
        test_reset_in_two();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data path width in bits.
REQ-002 The block SHALL have parameter INIT, default 0, the value loaded into both data registers on reset.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents in_data.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the oldest held payload.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes out_data this cycle.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all held entries (pipeline squash).
REQ-012 The block SHALL have port count, output, 2 bits: current occupancy, 0..2.

Function
REQ-013 in_fire SHALL be defined as in_valid & in_ready, and out_fire as out_valid & out_ready.
REQ-014 The block SHALL hold two entries, main and skid, under a three-state machine: EMPTY (count 0), ONE (main valid), TWO (main and skid valid).
REQ-015 out_valid SHALL be 1 in ONE and TWO, and out_data SHALL always drive the main register.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from state only, with no combinational path from out_ready or in_valid.
REQ-017 In EMPTY, in_fire SHALL load main with in_data and move to ONE; with no in_fire the block SHALL stay in EMPTY.
REQ-018 In ONE, simultaneous in_fire and out_fire SHALL load main with in_data and stay in ONE.
REQ-019 In ONE, in_fire without out_fire SHALL load skid with in_data and move to TWO.
REQ-020 In ONE, out_fire without in_fire SHALL move to EMPTY, and main SHALL retain its value.
REQ-021 In TWO, out_fire SHALL copy skid into main and move to ONE; with no out_fire the block SHALL hold both entries.
REQ-022 Entries SHALL leave in acceptance order; no entry is dropped or duplicated except by flush or reset.
REQ-023 Accepted data SHALL appear on out_data with one-cycle latency from in_fire when the block is EMPTY or draining.
REQ-024 Sustained in_valid=out_ready=1 SHALL give one transfer per cycle.
REQ-025 When flush=1 the block SHALL move to EMPTY at the next edge, ignoring in_fire and out_fire in that cycle; data registers keep their values.
REQ-026 in_ready SHALL still follow REQ-016 during a flush cycle; upstream treats that cycle's transfer as squashed.
REQ-027 out_data with out_valid=0 is don't-care for consumers but SHALL equal the last main value, never X after reset.
REQ-028 count SHALL equal 0, 1 or 2 in EMPTY, ONE or TWO respectively; the value 3 SHALL never occur.

Reset
REQ-029 With reset=0 at a rising edge the block SHALL enter EMPTY and load main and skid with INIT, regardless of flush, in_valid or out_ready.
REQ-030 After reset: out_valid=0, in_ready=1, count=0, out_data=INIT.
REQ-031 Reset asserted while in TWO SHALL discard both entries with no partial transfer.
REQ-032 Reset SHALL take priority over flush.

Verification
REQ-033 Reset with INIT=0x0 -> out_valid=0, in_ready=1, count=0, out_data=0x0.
REQ-034 Stall: push 0xA, 0xB, then 0xC with out_ready=0 -> count reaches 2, in_ready=0 and 0xC is not accepted; then out_ready=1 -> outputs 0xA, 0xB, then 0xC once presented again.
REQ-035 Streaming: in_valid=out_ready=1 with data 1..100 -> out_data shows 1..100 in order, one per cycle, count stays 1.
REQ-036 Flush in TWO holding 0x5,0x6 while in_valid=1 with 0x7 -> next cycle count=0, out_valid=0, 0x7 is not held.
REQ-037 Reset (reset=0) asserted in TWO with flush=1 -> EMPTY, out_data=INIT; a later push of 0x9 appears after one cycle.
REQ-038 Random valid/ready and flush against a reference queue model -> order and content always match, and in_ready never depends combinationally on out_ready.
